// File: rtl/disp_pkg.sv
// disp_pkg: shared mode/state encodings and blank drive constants for the display rotator
package disp_pkg;
  typedef enum logic [1:0] {
    MODE_AUTO     = 2'b00,
    MODE_HOLD     = 2'b01,
    MODE_STEP     = 2'b10,
    MODE_HOLD_ALT = 2'b11
  } mode_e;
  typedef enum logic {
    SHOW  = 1'b0,
    BLANK = 1'b1
  } state_e;
  localparam logic [6:0] SEG_OFF = 7'h7F;
  localparam logic [7:0] AN_OFF = 8'hFF;
endpackage

// File: rtl/period_tick.sv
// period_tick: one-cycle pulse every CLK_FREQ_HZ/1000*PERIOD_MS cycles, restartable via clr
module period_tick #(
  parameter int CLK_FREQ_HZ = 100_000_000,
  parameter int PERIOD_MS = 2000
)(
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);
  localparam int PERIOD = CLK_FREQ_HZ / 1000 * PERIOD_MS;
  localparam int W = $clog2(PERIOD + 1);
  logic [W-1:0] cnt;
  assign tick = !clr && cnt == W'(PERIOD - 1);
  // free-running dwell counter, wraps on its own pulse
  always_ff @(posedge clk) begin
    if (rst || clr || tick) cnt <= '0;
    else cnt <= cnt + 1'b1;
  end
endmodule

// File: rtl/display_rotator.sv
// display_rotator: selects one of N_CH seven-segment sources with blanking between switches
module display_rotator
  import disp_pkg::*;
#(
  parameter int N_CH = 4,
  parameter int CLK_FREQ_HZ = 100_000_000,
  parameter int PERIOD_MS = 2000,
  parameter int BLANK_CYC = 16
)(
  input  logic                    clk,
  input  logic                    rst,
  input  logic [1:0]              mode,
  input  logic                    step,
  input  logic [N_CH-1:0]         ch_en,
  input  logic [7*N_CH-1:0]       ch_segs_n,
  input  logic [8*N_CH-1:0]       ch_an_n,
  input  logic [N_CH-1:0]         ch_dp_n,
  output logic [6:0]              segs_n,
  output logic [7:0]              an_n,
  output logic                    dp_n,
  output logic [$clog2(N_CH)-1:0] cur_ch
);
  localparam int CW = $clog2(N_CH);
  state_e state, state_n;
  mode_e mode_q;
  logic [CW-1:0] cur_n, nxt;
  logic [7:0] bcnt, bcnt_n;
  logic tick, clr, any, adv, done;
  period_tick #(.CLK_FREQ_HZ(CLK_FREQ_HZ), .PERIOD_MS(PERIOD_MS)) u_tick (
    .clk(clk), .rst(rst), .clr(clr), .tick(tick)
  );
  // first enabled channel above cur_ch with wrap; scanning downward lets the nearest win
  always_comb begin
    int s;
    s = 0;
    nxt = cur_ch;
    for (int k = N_CH - 1; k >= 1; k--) begin
      s = int'(cur_ch) + k;
      s = s >= N_CH ? s - N_CH : s;
      nxt = ch_en[CW'(s)] ? CW'(s) : nxt;
    end
  end
  // advance detection, blank timing and channel commit at the end of blanking
  always_comb begin
    any = |ch_en;
    adv = (mode == MODE_AUTO && tick) || (mode == MODE_STEP && step) || !ch_en[cur_ch];
    done = state == BLANK && any && bcnt == 8'(BLANK_CYC - 1);
    state_n = state == SHOW ? ((adv && (!any || nxt != cur_ch)) ? BLANK : SHOW)
                            : (done ? SHOW : BLANK);
    cur_n = done ? nxt : cur_ch;
    bcnt_n = (state == BLANK && any && !done) ? bcnt + 8'd1 : 8'd0;
    clr = done || (mode == MODE_AUTO && mode_q != MODE_AUTO);
  end
  // state register and display drive registered from the upcoming state so they stay aligned
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= SHOW;
      cur_ch <= '0;
      bcnt <= '0;
      mode_q <= MODE_AUTO;
      segs_n <= SEG_OFF;
      an_n <= AN_OFF;
      dp_n <= 1'b1;
    end else begin
      state <= state_n;
      cur_ch <= cur_n;
      bcnt <= bcnt_n;
      mode_q <= mode_e'(mode);
      segs_n <= state_n == SHOW ? ch_segs_n[int'(cur_n) * 7 +: 7] : SEG_OFF;
      an_n <= state_n == SHOW ? ch_an_n[int'(cur_n) * 8 +: 8] : AN_OFF;
      dp_n <= state_n == SHOW ? ch_dp_n[cur_n] : 1'b1;
    end
  end
endmodule

// File: doc/display_rotator.md
DISPLAY_ROTATOR -- requirements
Module: display_rotator

Interface
REQ-001 Parameter N_CH, default 4, number of seven-segment display sources; range 2..8.
REQ-002 Parameter CLK_FREQ_HZ, default 100_000_000, clk frequency.
REQ-003 Parameter PERIOD_MS, default 2000, auto-rotate dwell time per channel.
REQ-004 Parameter BLANK_CYC, default 16, anode-blanking cycles inserted on every channel switch; range 1..255.
REQ-005 Port clk, input, 1, system clock.
REQ-006 Port rst, input, 1, synchronous active-high reset.
REQ-007 Port mode, input, 2, 00 auto-rotate, 01 hold, 10 manual step, 11 treated as hold.
REQ-008 Port step, input, 1, single-cycle pulse (debounced upstream), advance one channel in manual mode.
REQ-009 Port ch_en, input, N_CH, per-channel enable mask; disabled channels are skipped.
REQ-010 Port ch_segs_n, input, 7*N_CH, channel i segments at [7i+6:7i], active-low.
REQ-011 Port ch_an_n, input, 8*N_CH, channel i anodes at [8i+7:8i], active-low.
REQ-012 Port ch_dp_n, input, N_CH, channel i decimal point, active-low.
REQ-013 Port segs_n / an_n / dp_n, output, 7 / 8 / 1, selected display drive, active-low.
REQ-014 Port cur_ch, output, $clog2(N_CH), index of the currently selected channel.

Function
REQ-015 Tick: an internal counter SHALL pulse once every CLK_FREQ_HZ/1000*PERIOD_MS cycles; the counter SHALL clear on a mode change into 00 and on any channel switch.
REQ-016 FSM states SHOW and BLANK; SHOW -> BLANK on an advance event; BLANK -> SHOW after exactly BLANK_CYC cycles, at which point cur_ch takes the new value.
REQ-017 Advance events: tick in mode 00; step in mode 10; current channel disabled (ch_en[cur_ch]=0) in any mode; step in modes 00/01/11 SHALL be ignored.
REQ-018 Next channel SHALL be the first index with ch_en set after cur_ch, searching upward with wrap from N_CH-1 to 0; if only cur_ch is enabled, no switch and no blanking occur.
REQ-019 If ch_en is all zero, the block SHALL stay in/enter BLANK, hold cur_ch, and return to normal operation on the cycle after any bit of ch_en sets.
REQ-020 Advance events arriving during BLANK SHALL be discarded (no queuing).
REQ-021 Outputs SHALL be registered: one-cycle latency from ch_* inputs to segs_n/an_n/dp_n.
REQ-022 In SHOW, outputs SHALL equal channel cur_ch fields; in BLANK, an_n=8'hFF, segs_n=7'h7F, dp_n=1.
REQ-023 Mode change SHALL take effect the next cycle and SHALL NOT by itself trigger a switch.

Reset
REQ-024 On rst: cur_ch=0, state SHOW, tick counter=0, blank counter=0, registered outputs all ones (blank) for the reset cycle.
REQ-025 Reset asserted mid-BLANK SHALL abort the blank and return to channel 0; if ch_en[0]=0 after reset, REQ-017 applies on the first cycle.

Structure
REQ-026 Shared package disp_pkg SHALL hold the mode encoding enum, the SHOW/BLANK state enum, and SEG_OFF/AN_OFF constants.
REQ-027 Tick generation SHALL be a single sub-module, period_tick (parameters CLK_FREQ_HZ, PERIOD_MS; ports clk, rst, clr, tick).

Verification
REQ-028 CLK_FREQ_HZ=1000, PERIOD_MS=4, BLANK_CYC=2, N_CH=4, ch_en=4'b1111, mode=00 -> cur_ch sequence 0,1,2,3,0, each SHOW lasting 4 cycles, each switch preceded by 2 cycles of an_n=8'hFF.
REQ-029 mode=10, ch_en=4'b1010, cur_ch=1, step pulse -> 2 blank cycles then cur_ch=3; second step -> cur_ch=1 (wrap).
REQ-030 mode=01, cur_ch=2, clear ch_en[2] -> blank starts next cycle, cur_ch=3 after BLANK_CYC.
REQ-031 ch_en=0 -> an_n=8'hFF held indefinitely; set ch_en=4'b0100 -> switch to cur_ch=2 after blank.
REQ-032 rst asserted during BLANK -> next cycle cur_ch=0, state SHOW, tick restarts from 0.
REQ-033 mode=00, step pulses every cycle -> no extra switches; channel i data 7'h12 on ch_segs_n appears on segs_n one cycle later.
